// File: rtl/fibonacci_checker.sv
// fibonacci_checker
//   Consumer-side checker for single/double-rate Fibonacci streams. Accepts
//   one or two numbers per cycle and verifies each number is the mod-2^W sum
//   of the two before it. Counts accepted numbers (saturating) and captures
//   the first mismatch in sticky registers. Always ready, no backpressure.
//
//   State table
//   state | meaning
//   EMPTY | no number seen since clear
//   ONE   | one number seen, held in a
//   RUN   | two or more numbers seen, a (older) / b (newer) valid
//   FAIL  | mismatch captured; all beats ignored until clear
//
//   Ports
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   restart    synchronous clear, same effect as rst
//   in_valid   beat present this cycle
//   in_two     1 = num and num2 valid (num older), 0 = num only
//   num, num2  stream data
//   count      numbers accepted since clear, saturating
//   err        sticky first-mismatch flag
//   err_index  0-based stream index of the first bad number
//   err_exp    expected value at err_index
//   err_got    received value at err_index
//   busy       at least one number accepted
module fibonacci_checker #(
   parameter int W          = 16,
   parameter int CNT_W      = 16,
   parameter bit CHECK_SEED = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             restart,
   input  logic             in_valid,
   input  logic             in_two,
   input  logic [W-1:0]     num,
   input  logic [W-1:0]     num2,
   output logic [CNT_W-1:0] count,
   output logic             err,
   output logic [CNT_W-1:0] err_index,
   output logic [W-1:0]     err_exp,
   output logic [W-1:0]     err_got,
   output logic             busy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAIL  = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] err_index_q, err_index_d;
   logic [W-1:0]     err_exp_q, err_exp_d;
   logic [W-1:0]     err_got_q, err_got_d;
   logic             busy_q, busy_d;

   logic [W-1:0]     e0, e1, exp0, exp1;
   logic             chk0, chk1, bad0, bad1;
   logic [CNT_W:0]   cnt_sum;
   logic [CNT_W-1:0] cnt_inc;

   localparam logic [W-1:0]     ONE_W   = W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Saturating count add; the increment depends on how many lanes were taken.
   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                input logic [1:0] inc);
      logic [CNT_W:0] s;
      s = {1'b0, base} + {{(CNT_W-1){1'b0}}, inc};
      return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
   endfunction

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      count_d     = count_q;
      err_d       = err_q;
      err_index_d = err_index_q;
      err_exp_d   = err_exp_q;
      err_got_d   = err_got_q;
      e0          = a_q + b_q;
      e1          = b_q + e0;
      exp0        = '0;
      exp1        = '0;
      chk0        = 1'b0;
      chk1        = 1'b0;
      cnt_sum     = '0;
      cnt_inc     = '0;

      // Per-lane expectation; seeds are only checked against 1 when enabled.
      case (state_q)
         ST_EMPTY: begin
            exp0 = ONE_W;
            exp1 = ONE_W;
            chk0 = CHECK_SEED;
            chk1 = CHECK_SEED;
         end
         ST_ONE: begin
            exp0 = ONE_W;
            exp1 = a_q + num;
            chk0 = CHECK_SEED;
            chk1 = 1'b1;
         end
         ST_RUN: begin
            exp0 = e0;
            exp1 = e1;
            chk0 = 1'b1;
            chk1 = 1'b1;
         end
         default: ;
      endcase

      bad0 = chk0 && (num != exp0);
      bad1 = in_two && chk1 && (num2 != exp1);

      if (in_valid && state_q != ST_FAIL) begin
         if (bad0) begin
            count_d     = sat_add(count_q, 2'd1);
            err_d       = 1'b1;
            err_index_d = count_q;
            err_exp_d   = exp0;
            err_got_d   = num;
            state_d     = ST_FAIL;
         end else if (bad1) begin
            count_d     = sat_add(count_q, 2'd2);
            err_d       = 1'b1;
            err_index_d = count_q + CNT_W'(1);
            err_exp_d   = exp1;
            err_got_d   = num2;
            state_d     = ST_FAIL;
         end else begin
            count_d = sat_add(count_q, in_two ? 2'd2 : 2'd1);
            case (state_q)
               ST_EMPTY: begin
                  a_d = num;
                  if (in_two) begin
                     b_d     = num2;
                     state_d = ST_RUN;
                  end else begin
                     state_d = ST_ONE;
                  end
               end
               ST_ONE: begin
                  if (in_two) begin
                     a_d = num;
                     b_d = num2;
                  end else begin
                     b_d = num;
                  end
                  state_d = ST_RUN;
               end
               default: begin
                  if (in_two) begin
                     a_d = num;
                     b_d = num2;
                  end else begin
                     a_d = b_q;
                     b_d = num;
                  end
               end
            endcase
         end
      end

      busy_d = (state_d != ST_EMPTY);
   end

   always_ff @(posedge clk) begin
      if (rst || restart) begin
         state_q     <= ST_EMPTY;
         a_q         <= '0;
         b_q         <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         err_index_q <= '0;
         err_exp_q   <= '0;
         err_got_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         count_q     <= count_d;
         err_q       <= err_d;
         err_index_q <= err_index_d;
         err_exp_q   <= err_exp_d;
         err_got_q   <= err_got_d;
         busy_q      <= busy_d;
      end
   end

   assign count     = count_q;
   assign err       = err_q;
   assign err_index = err_index_q;
   assign err_exp   = err_exp_q;
   assign err_got   = err_got_q;
   assign busy      = busy_q;

endmodule
